// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types, constants and bus-level helper for the I2C
//               write master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        ACKB  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef logic [1:0] phase_t;

    localparam logic       I2C_WRITE   = 1'b0;
    localparam logic [6:0] WM8731_ADDR = 7'b0011010;

    // Returns {scl, sda} for a given state/phase; b is the data bit in DATA.
    function automatic logic [1:0] bus_levels(input state_t s, input phase_t p, input logic b);
        logic w_scl_high;
        logic [1:0] w_lv;
        w_scl_high = (p == 2'd1) || (p == 2'd2);
        case (s)
            START: begin
                case (p)
                    2'd0:    w_lv = 2'b11;
                    2'd3:    w_lv = 2'b00;
                    default: w_lv = 2'b10;
                endcase
            end
            DATA:    w_lv = {w_scl_high, b};
            ACKB:    w_lv = {w_scl_high, 1'b1};
            STOP: begin
                case (p)
                    2'd0:    w_lv = 2'b00;
                    2'd1:    w_lv = 2'b10;
                    default: w_lv = 2'b11;
                endcase
            end
            default: w_lv = 2'b11;
        endcase
        return w_lv;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_write_master_if.sv
// ============================================================================
// Module      : i2c_write_master_if
// Description : Request handshake and I2C pad signals of the write master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_write_master_if #(
    parameter int NBYTES = 2
);
    logic [6:0]             addr;
    logic [NBYTES-1:0][7:0] wdata;
    logic                   req;
    logic                   ack;
    logic                   nack;
    logic                   busy;
    logic                   scl_o;
    logic                   sda_o;
    logic                   sda_i;

    modport master (
        input  addr, wdata, req, sda_i,
        output ack, nack, busy, scl_o, sda_o
    );

    modport slave (
        output addr, wdata, req, sda_i,
        input  ack, nack, busy, scl_o, sda_o
    );
endinterface

`default_nettype wire

// File: rtl/i2c_write_master_sync2.sv
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

`default_nettype wire

// File: rtl/i2c_write_master.sv
// ============================================================================
// Module      : i2c_write_master
// Description : Write-only I2C master; START, address+W, NBYTES data, STOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    i2c_write_master_if.master    bus
);
    localparam int c_SR_W   = (NBYTES + 1) * 8;
    localparam int c_BYTE_W = (NBYTES > 0) ? $clog2(NBYTES + 1) : 1;
    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(NBYTES);

    state_t              r_state, w_state_nxt;
    phase_t              r_phase, w_phase_nxt;
    logic [2:0]          r_bit, w_bit_nxt;
    logic [c_BYTE_W-1:0] r_byte, w_byte_nxt;
    logic [c_SR_W-1:0]   r_shift, w_shift_nxt;
    logic                r_scl, w_scl_nxt;
    logic                r_sda, w_sda_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_nack, w_nack_nxt;
    logic                r_busy, w_busy_nxt;
    logic                w_accept;
    logic                w_sda_sync;

    sync2 #(.RESET_VAL(1'b1)) u_sda_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (bus.sda_i),
        .o_q     (w_sda_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_phase <= 2'd0;
            r_bit   <= 3'd0;
            r_byte  <= '0;
            r_shift <= '0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_ack   <= 1'b0;
            r_nack  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_shift <= w_shift_nxt;
            r_scl   <= w_scl_nxt;
            r_sda   <= w_sda_nxt;
            r_ack   <= w_ack_nxt;
            r_nack  <= w_nack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
        w_ack_nxt   = r_ack;
        w_nack_nxt  = r_nack;
        w_busy_nxt  = r_busy;
        w_accept    = 1'b0;

        unique case (r_state)
            IDLE: w_accept = bus.req;
            START: begin
                w_phase_nxt = r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = 3'd7;
                    w_byte_nxt  = '0;
                end
            end
            DATA: begin
                w_phase_nxt = r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    w_shift_nxt = {r_shift[c_SR_W-2:0], 1'b0};
                    if (r_bit == 3'd0) begin
                        w_state_nxt = ACKB;
                    end else begin
                        w_bit_nxt = r_bit - 3'd1;
                    end
                end
            end
            ACKB: begin
                w_phase_nxt = r_phase + 2'd1;
                // nack was cleared on accept, so it doubles as "this byte was NACKed"
                if (r_phase == 2'd2 && w_sda_sync) begin
                    w_nack_nxt = 1'b1;
                end
                if (r_phase == 2'd3) begin
                    if (r_nack || (r_byte == c_LAST_BYTE)) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_state_nxt = DATA;
                        w_byte_nxt  = r_byte + c_BYTE_W'(1);
                        w_bit_nxt   = 3'd7;
                    end
                end
            end
            STOP: begin
                w_phase_nxt = r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    w_state_nxt = DONE;
                    w_ack_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            DONE: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = IDLE;
                w_accept    = bus.req;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_accept) begin
            w_state_nxt = START;
            w_phase_nxt = 2'd0;
            w_shift_nxt = {bus.addr, I2C_WRITE, bus.wdata};
            w_busy_nxt  = 1'b1;
            w_nack_nxt  = 1'b0;
        end

        // Pads are registered from the next position so they line up with the state.
        {w_scl_nxt, w_sda_nxt} = bus_levels(w_state_nxt, w_phase_nxt, w_shift_nxt[c_SR_W-1]);
    end

    assign bus.ack   = r_ack;
    assign bus.nack  = r_nack;
    assign bus.busy  = r_busy;
    assign bus.scl_o = r_scl;
    assign bus.sda_o = r_sda;
endmodule

`default_nettype wire
